// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: aligns an MSB-first bit stream on repeated
// comma characters, then presents each received byte with a data-valid flag.
module serial_paralelo_rx #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serialIn,
  output logic [7:0] dataOut,
  output logic       validOut,
  output logic       active,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] BC_TARGET = 3'(BC_COUNT);

  state_t     state;
  logic [7:0] sr;
  logic [2:0] cnt;
  logic [2:0] bc_cnt;
  logic [7:0] w;
  logic       boundary;
  logic       is_comma;

  // w is the byte whose last bit arrives on this edge.
  assign w         = {sr[6:0], serialIn};
  assign boundary  = (cnt == 3'd7);
  assign is_comma  = (w == COMMA);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      sr       <= 8'h00;
      cnt      <= 3'd0;
      bc_cnt   <= 3'd0;
      dataOut  <= 8'h00;
      validOut <= 1'b0;
      active   <= 1'b0;
    end else begin
      sr  <= w;
      cnt <= cnt + 3'd1;
      case (state)
        SEARCH: begin
          // A comma here defines the byte boundary: restart the bit counter.
          if (is_comma) begin
            cnt    <= 3'd0;
            bc_cnt <= 3'd1;
            if (BC_TARGET == 3'd1) begin
              state  <= LOCKED;
              active <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (boundary) begin
            if (is_comma) begin
              bc_cnt <= bc_cnt + 3'd1;
              if (bc_cnt + 3'd1 == BC_TARGET) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              bc_cnt <= 3'd0;
              state  <= SEARCH;
            end
          end
        end
        LOCKED: begin
          // Lock is sticky; only reset can leave this state.
          if (boundary) begin
            dataOut  <= w;
            validOut <= !is_comma;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed scenarios plus random streams,
// every cycle compared against a bit-history alignment model.
module tb_serial_paralelo_rx;

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam int         BC_COUNT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serialIn = 1'b0;
  logic [7:0] dataOut;
  logic       validOut;
  logic       active;
  logic [1:0] dbg_state;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic hist[$];

  serial_paralelo_rx #(.COMMA(COMMA), .BC_COUNT(BC_COUNT)) dut (
    .clk(clk), .reset(reset), .serialIn(serialIn),
    .dataOut(dataOut), .validOut(validOut), .active(active),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic assert_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    hist.delete();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // driver: one bit per rising edge, outputs observed 1 time unit after it
  task automatic send_bit(input logic b);
    @(negedge clk);
    serialIn = b;
    @(posedge clk);
    hist.push_back(b);
    #1;
  endtask

  // reference model: byte ending at bit index i (bits before reset read as 0)
  function automatic logic [7:0] win(input int i);
    logic [7:0] r = 8'h00;
    for (int k = i - 7; k <= i; k++) r = {r[6:0], (k >= 0) ? hist[k] : 1'b0};
    return r;
  endfunction

  // Scan the history: find a comma, require BC_COUNT-1 more commas every 8 bits;
  // on a break resume the bitwise search just after the breaking byte.
  function automatic void model(output logic [7:0] d, output logic v, output logic a);
    int n = hist.size();
    int i = 0;
    int lock = -1;
    int c;
    d = 8'h00; v = 1'b0; a = 1'b0;
    while (i < n && lock < 0) begin
      if (win(i) == COMMA) begin
        int bad = -1;
        bit incomplete = 1'b0;
        for (int k = 1; k < BC_COUNT && bad < 0 && !incomplete; k++) begin
          if (i + 8 * k >= n) incomplete = 1'b1;
          else if (win(i + 8 * k) != COMMA) bad = i + 8 * k;
        end
        if (incomplete) return;
        if (bad >= 0) i = bad + 1;
        else lock = i + 8 * (BC_COUNT - 1);
      end else begin
        i++;
      end
    end
    if (lock < 0) return;
    a = 1'b1;
    c = lock + 8 * ((n - 1 - lock) / 8);
    if (c > lock) begin
      d = win(c);
      v = (d != COMMA);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    hist.delete();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      serialIn = k[0];
      @(posedge clk);
      #1;
      check_cnt++;
      if ({active, validOut, dataOut} !== 10'h000)
        $display("FAIL reset_hold cyc=%0d got a=%b v=%b d=%h want 0/0/00", k, active, validOut, dataOut);
      else pass_cnt++;
    end
    release_reset();
  endtask

  task automatic test_lock();
    logic [7:0] ed; logic ev, ea;
    for (int k = 0; k < 4; k++) begin
      for (int j = 7; j >= 0; j--) begin
        send_bit(COMMA[j]);
        model(ed, ev, ea);
        check_cnt++;
        if ({active, validOut, dataOut} !== {ea, ev, ed})
          $display("FAIL lock_model k=%0d j=%0d got %b/%b/%h want %b/%b/%h", k, j, active, validOut, dataOut, ea, ev, ed);
        else pass_cnt++;
        if (k == 3 && j == 1) begin
          check_cnt++;
          if (active !== 1'b0) $display("FAIL lock_early got active=%b want 0", active);
          else pass_cnt++;
        end
      end
    end
    check_cnt++;
    if (active !== 1'b1 || validOut !== 1'b0)
      $display("FAIL lock_rise got active=%b valid=%b want 1/0", active, validOut);
    else pass_cnt++;
  endtask

  task automatic test_data();
    logic [7:0] bytes[$] = '{8'h5A, 8'hFF, 8'hBC, 8'h01};
    logic       vals[$]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] b;
    logic [7:0] ed; logic ev, ea;
    for (int k = 0; k < bytes.size(); k++) begin
      b = bytes[k];
      for (int j = 7; j >= 0; j--) begin
        send_bit(b[j]);
        model(ed, ev, ea);
        check_cnt++;
        if ({active, validOut, dataOut} !== {ea, ev, ed})
          $display("FAIL data_model k=%0d j=%0d got %b/%b/%h want %b/%b/%h", k, j, active, validOut, dataOut, ea, ev, ed);
        else pass_cnt++;
      end
      check_cnt++;
      if (dataOut !== b || validOut !== vals[k])
        $display("FAIL data_byte k=%0d got d=%h v=%b want d=%h v=%b", k, dataOut, validOut, b, vals[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_broken_lock();
    logic [7:0] bytes[$] = '{8'hBC, 8'hBC, 8'h12, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
    logic [7:0] b;
    logic [7:0] ed; logic ev, ea;
    assert_reset();
    release_reset();
    for (int k = 0; k < bytes.size(); k++) begin
      b = bytes[k];
      for (int j = 7; j >= 0; j--) begin
        send_bit(b[j]);
        model(ed, ev, ea);
        check_cnt++;
        if ({active, validOut, dataOut} !== {ea, ev, ed})
          $display("FAIL broken_model k=%0d j=%0d got %b/%b/%h want %b/%b/%h", k, j, active, validOut, dataOut, ea, ev, ed);
        else pass_cnt++;
      end
      check_cnt++;
      if (active !== (k == 6))
        $display("FAIL broken_active k=%0d got %b want %b", k, active, (k == 6));
      else pass_cnt++;
    end
  endtask

  task automatic test_misalign();
    logic bits[$] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] seq[$] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5};
    logic [7:0] b;
    logic [7:0] ed; logic ev, ea;
    assert_reset();
    release_reset();
    for (int k = 0; k < seq.size(); k++) begin
      b = seq[k];
      for (int j = 7; j >= 0; j--) bits.push_back(b[j]);
    end
    for (int k = 0; k < bits.size(); k++) begin
      send_bit(bits[k]);
      model(ed, ev, ea);
      check_cnt++;
      if ({active, validOut, dataOut} !== {ea, ev, ed})
        $display("FAIL misalign_model bit=%0d got %b/%b/%h want %b/%b/%h", k, active, validOut, dataOut, ea, ev, ed);
      else pass_cnt++;
      if (k == bits.size() - 2) begin
        check_cnt++;
        if (dataOut !== 8'h00 || validOut !== 1'b0)
          $display("FAIL misalign_early got d=%h v=%b want 00/0", dataOut, validOut);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (dataOut !== 8'hA5 || validOut !== 1'b1 || active !== 1'b1)
      $display("FAIL misalign_a5 got d=%h v=%b a=%b want a5/1/1", dataOut, validOut, active);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq[$] = '{8'h33, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h33};
    logic [7:0] b;
    logic [7:0] ed; logic ev, ea;
    for (int j = 0; j < 4; j++) send_bit(1'($urandom_range(0, 1)));
    check_cnt++;
    if (active !== 1'b1) $display("FAIL mid_pre got active=%b want 1", active);
    else pass_cnt++;
    @(posedge clk);
    #2;
    reset = 1'b0;
    hist.delete();
    #1;
    check_cnt++;
    if ({active, validOut, dataOut} !== 10'h000)
      $display("FAIL mid_async got %b/%b/%h want 0/0/00", active, validOut, dataOut);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    release_reset();
    for (int k = 0; k < seq.size(); k++) begin
      b = seq[k];
      for (int j = 7; j >= 0; j--) begin
        send_bit(b[j]);
        model(ed, ev, ea);
        check_cnt++;
        if ({active, validOut, dataOut} !== {ea, ev, ed})
          $display("FAIL mid_model k=%0d j=%0d got %b/%b/%h want %b/%b/%h", k, j, active, validOut, dataOut, ea, ev, ed);
        else pass_cnt++;
      end
      if (k == 0) begin
        check_cnt++;
        if (validOut !== 1'b0 || active !== 1'b0)
          $display("FAIL mid_lone33 got v=%b a=%b want 0/0", validOut, active);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (dataOut !== 8'h33 || validOut !== 1'b1)
      $display("FAIL mid_relock got d=%h v=%b want 33/1", dataOut, validOut);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] ed; logic ev, ea;
    for (int run = 0; run < 4; run++) begin
      assert_reset();
      release_reset();
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          send_bit(1'($urandom_range(0, 1)));
          model(ed, ev, ea);
          check_cnt++;
          if ({active, validOut, dataOut} !== {ea, ev, ed})
            $display("FAIL rand_model run=%0d junk k=%0d got %b/%b/%h want %b/%b/%h", run, k, active, validOut, dataOut, ea, ev, ed);
          else pass_cnt++;
        end else begin
          b = ($urandom_range(0, 1) == 0) ? COMMA : 8'($urandom_range(0, 255));
          for (int j = 7; j >= 0; j--) begin
            send_bit(b[j]);
            model(ed, ev, ea);
            check_cnt++;
            if ({active, validOut, dataOut} !== {ea, ev, ed})
              $display("FAIL rand_model run=%0d k=%0d j=%0d got %b/%b/%h want %b/%b/%h", run, k, j, active, validOut, dataOut, ea, ev, ed);
            else pass_cnt++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_data();
    test_broken_lock();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Receive-side deserializer that consumes the 1-bit serial stream produced by the transmit PHY. The stream carries MSB-first bytes, with comma 0xBC sent whenever no valid data is present. The block finds byte alignment by locking onto consecutive commas, then emits each received byte with a valid flag (low for commas). It sits directly downstream of the transmit PHY serializer and feeds the receive-side demux tree.

## Interface
- COMMA, 8'hBC, idle/alignment character.
- BC_COUNT, 4, consecutive boundary-aligned commas required to lock (legal range 1..7).

Ports:
- clk  in  1  bit clock, 32f domain, one serial bit per rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- serialIn  in  1  serial data, MSB first.
- dataOut  out  8  last received byte, held for 8 cycles.
- validOut  out  1  high when dataOut is a non-comma byte received while locked.
- active  out  1  high once alignment is locked; sticky until reset.

## Operation
- Shift register sr[7:0] <= {sr[6:0], serialIn} every edge. Combinational window w = {sr[6:0], serialIn} is the byte completing at this edge.
- 3-bit bit counter cnt. A boundary is the edge where cnt==7; cnt wraps to 0 after it.
- bc_cnt counts aligned commas; 3 bits wide.
- States: SEARCH, COUNT, LOCKED.
- SEARCH: test w every edge.
  - On w==COMMA: cnt<=0, bc_cnt<=1, go to COUNT.
  - If BC_COUNT==1, go directly to LOCKED instead.
- COUNT: test w only at boundaries.
  - w==COMMA: bc_cnt++. When the new value equals BC_COUNT, go to LOCKED.
  - w!=COMMA: bc_cnt<=0, go to SEARCH.
- LOCKED: at each boundary, dataOut<=w and validOut<=(w!=COMMA). No loss-of-lock detection; only reset leaves LOCKED.
- active = (state==LOCKED), registered.
- Non-boundary edges never change dataOut or validOut.
- Commas at non-aligned offsets in COUNT or LOCKED are ignored.

## Timing
- Reset values: dataOut=8'h00, validOut=0, active=0, state=SEARCH, cnt=0, bc_cnt=0, sr=0.
- Reset assertion is asynchronous and clears outputs without a clock edge. After release, the first sampled bit is at the next rising edge.
- Lock timing, BC_COUNT=4:
  - First comma's last bit sampled at edge t.
  - Further commas complete at t+8, t+16, t+24.
  - active=1 after edge t+24.
- Data latency: a byte whose last bit is sampled at edge b appears on dataOut/validOut after edge b, i.e. 0 extra cycles past the final bit.
- After lock, the first data boundary is t+32.
- Each output value is held exactly 8 cycles.
- Simultaneous boundary and state transition: the LOCKED capture does not occur on the edge that enters LOCKED. The first capture is the next boundary.
- Reset mid-operation, in any state: everything returns to reset values. Re-locking requires BC_COUNT fresh aligned commas.

## Test plan
- Reset: hold reset=0 for 20 cycles while serialIn toggles -> dataOut=0x00, validOut=0, active=0 throughout.
- Lock: after release, send 4×0xBC MSB first -> active rises after the 32nd bit's edge; validOut stays 0.
- Data: after lock, send 0x5A, 0xFF, 0xBC, 0x01, each held 8 cycles. Required:
  - 0x5A, validOut=1.
  - 0xFF, validOut=1.
  - 0xBC, validOut=0.
  - 0x01, validOut=1.
- Broken lock: send 0xBC, 0xBC, 0x12, then 4×0xBC -> active stays 0 through 0x12. active rises only after the 4th comma following 0x12.
- Misalignment: 3 junk bits (1,0,1), then 4×0xBC, then 0xA5 -> locks; dataOut=0xA5, validOut=1 at the correct boundary.
- Reset mid-stream: assert reset between clock edges mid-byte while locked -> outputs clear immediately. After release, 0x33 alone does not assert validOut; 4×0xBC then 0x33 does.
